// File: rtl/sd_activity_monitor.sv
// Multi-channel SPI/SD activity detector. Each channel holds a retriggerable
// activity flag after any counted MOSI/MISO toggle and drives a solid or blinking LED.

module sd_act_chan #(
    parameter int TIMEOUT     = 1000000,
    parameter int GATE_SS     = 1,
    parameter int POWERON_ACT = 1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic mosi,
    input  logic miso,
    input  logic ss_n,
    output logic act_next,
    output logic act
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    logic          prev_mosi, prev_miso;
    logic [CW-1:0] cnt;
    logic          tgl;
    logic          ss_ok;

    assign ss_ok    = (GATE_SS != 0) ? ~ss_n : 1'b1;
    assign tgl      = ((prev_mosi ^ mosi) | (prev_miso ^ miso)) & ss_ok;
    // Activity is judged on the count before any restart this cycle.
    assign act_next = (cnt < CNT_MAX);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Capture live pins so the first cycle after reset sees no edge.
            prev_mosi <= mosi;
            prev_miso <= miso;
            cnt       <= (POWERON_ACT != 0) ? '0 : CNT_MAX;
            act       <= 1'b0;
        end else begin
            prev_mosi <= mosi;
            prev_miso <= miso;
            if (tgl)
                cnt <= '0;
            else if (cnt < CNT_MAX)
                cnt <= cnt + CW'(1);
            act <= act_next;
        end
    end
endmodule

module sd_activity_monitor #(
    parameter int NCH         = 2,
    parameter int TIMEOUT     = 1000000,
    parameter int BLINK_DIV   = 2000000,
    parameter int GATE_SS     = 1,
    parameter int POWERON_ACT = 1
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic [NCH-1:0] mosi,
    input  logic [NCH-1:0] miso,
    input  logic [NCH-1:0] ss_n,
    input  logic [NCH-1:0] mode,
    output logic [NCH-1:0] act,
    output logic [NCH-1:0] led,
    output logic           act_any
);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] PRESC_TC = BW'(BLINK_DIV - 1);

    logic [NCH-1:0] act_next;
    logic [BW-1:0]  presc;
    logic           blink_phase;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        sd_act_chan #(
            .TIMEOUT    (TIMEOUT),
            .GATE_SS    (GATE_SS),
            .POWERON_ACT(POWERON_ACT)
        ) u_chan (
            .clk_sys (clk_sys),
            .reset   (reset),
            .mosi    (mosi[i]),
            .miso    (miso[i]),
            .ss_n    (ss_n[i]),
            .act_next(act_next[i]),
            .act     (act[i])
        );
    end

    // One prescaler shared by all channels keeps blinking LEDs in phase.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            presc       <= '0;
            blink_phase <= 1'b1;
        end else if (presc == PRESC_TC) begin
            presc       <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            presc <= presc + BW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            led     <= '0;
            act_any <= 1'b0;
        end else begin
            led     <= act_next & (~mode | {NCH{blink_phase}});
            act_any <= |act_next;
        end
    end
endmodule

// File: tb/tb_sd_activity_monitor.sv
// Randomized plus directed bench for sd_activity_monitor; two instances cover
// POWERON_ACT=1 and 0 and are checked every cycle against an event-time model.
`timescale 1ns/1ps
module tb_sd_activity_monitor;
    localparam int NCH = 2;
    localparam int T   = 8;
    localparam int BD  = 4;

    logic           clk_sys = 1'b0;
    logic           reset   = 1'b1;
    logic [NCH-1:0] mosi    = '0;
    logic [NCH-1:0] miso    = '0;
    logic [NCH-1:0] ss_n    = '1;
    logic [NCH-1:0] mode    = '0;
    logic [NCH-1:0] act1, led1, act0, led0;
    logic           any1, any0;

    always #5 clk_sys = ~clk_sys;

    sd_activity_monitor #(.NCH(NCH), .TIMEOUT(T), .BLINK_DIV(BD), .GATE_SS(1), .POWERON_ACT(1)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .mosi(mosi), .miso(miso), .ss_n(ss_n),
        .mode(mode), .act(act1), .led(led1), .act_any(any1));
    sd_activity_monitor #(.NCH(NCH), .TIMEOUT(T), .BLINK_DIV(BD), .GATE_SS(1), .POWERON_ACT(0)) dut0 (
        .clk_sys(clk_sys), .reset(reset), .mosi(mosi), .miso(miso), .ss_n(ss_n),
        .mode(mode), .act(act0), .led(led0), .act_any(any0));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_cyc = 0;
    // Model: per instance/channel, cycle of the last activity-starting event.
    int last_e [2][NCH];
    bit has_e  [2][NCH];
    logic [NCH-1:0] pm = '0, pmi = '0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        logic [NCH-1:0] tg;
        logic [NCH-1:0] ea [2];
        logic [NCH-1:0] el [2];
        logic ph;
        @(posedge clk_sys);
        cyc++;
        tg = ((pm ^ mosi) | (pmi ^ miso)) & ~ss_n;
        for (int p = 0; p < 2; p++) begin
            ea[p] = '0;
            el[p] = '0;
        end
        if (reset) begin
            rst_cyc = cyc;
            for (int i = 0; i < NCH; i++) begin
                has_e[1][i] = 1'b1;  last_e[1][i] = cyc;
                has_e[0][i] = 1'b0;  last_e[0][i] = 0;
            end
        end else begin
            ph = 1'b1 ^ ((((cyc - 1 - rst_cyc) / BD) % 2) != 0);
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < NCH; i++) begin
                    ea[p][i] = has_e[p][i] && ((cyc - last_e[p][i]) <= T);
                    el[p][i] = ea[p][i] & (mode[i] ? ph : 1'b1);
                    if (tg[i]) begin
                        has_e[p][i] = 1'b1;
                        last_e[p][i] = cyc;
                    end
                end
        end
        pm  = mosi;
        pmi = miso;
        #1;
        chk("act_p1", 8'(act1), 8'(ea[1]));
        chk("led_p1", 8'(led1), 8'(el[1]));
        chk("any_p1", 8'(any1), 8'(|ea[1]));
        chk("act_p0", 8'(act0), 8'(ea[0]));
        chk("led_p0", 8'(led0), 8'(el[0]));
        chk("any_p0", 8'(any0), 8'(|ea[0]));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // Power-on activity window
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(12);
        // Single gated mosi toggle on channel 0
        ss_n[0] = 1'b0;
        ticks(1);
        mosi[0] = 1'b1;
        ticks(12);
        // Gated-off miso toggling on channel 1, then ungated
        ss_n[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin miso[1] = ~miso[1]; tick(); end
        ss_n[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin miso[1] = ~miso[1]; tick(); end
        ticks(12);
        // Retrigger at k, k+6, then again right at saturation
        mosi[0] = ~mosi[0]; tick();
        ticks(5);
        mosi[0] = ~mosi[0]; tick();
        ticks(7);
        mosi[0] = ~mosi[0]; tick();
        ticks(12);
        // Blinking LED under continuous activity, then back to solid
        mode[0] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k % 3 == 0) mosi[0] = ~mosi[0];
            tick();
        end
        mode[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k % 3 == 0) mosi[0] = ~mosi[0];
            tick();
        end
        ticks(12);
        // Reset mid-activity with mosi held high across release
        mosi[0] = 1'b0; tick();
        mosi[0] = 1'b1; tick();
        ticks(3);
        reset = 1'b1; tick();
        reset = 1'b0;
        ticks(14);
        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 11) == 0) mosi[i] = ~mosi[i];
                if ($urandom_range(0, 11) == 0) miso[i] = ~miso[i];
                if ($urandom_range(0, 19) == 0) ss_n[i] = ~ss_n[i];
                if ($urandom_range(0, 29) == 0) mode[i] = ~mode[i];
            end
            tick();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
